// File: rtl/tot_hit_fifo_if.sv
// Readout stream between the TOT hit FIFO and the serializer/DAQ.
// The FIFO side uses the master modport, the consumer uses slave.
interface tot_hit_fifo_if;
    logic        rdValid;
    logic        rdReady;
    logic [15:0] rdData;

    modport master (
        output rdValid,
        output rdData,
        input  rdReady
    );

    modport slave (
        input  rdValid,
        input  rdData,
        output rdReady
    );
endinterface

// File: rtl/tot_hit_fifo.sv
// TOT hit FIFO: registers encoded hits, forms the 9-bit TOT code,
// tags each hit with a rolling 6-bit event ID and buffers it in a
// first-word-fall-through FIFO drained over a valid/ready port.
// Optional TOT window filter is compiled in with `define TOT_WINDOW_EN.
module tot_hit_fifo #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int TOT_MIN = 0,
    parameter int TOT_MAX = 511
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_hitValid,
    input  logic [2:0]        i_coarsePhase,
    input  logic [5:0]        i_finePhase,
    input  logic              i_errorFlag,
    input  logic              i_dropErrors,
    input  logic              i_clearStats,
    tot_hit_fifo_if.master    o_rd,
    output logic [ADDR_W:0]   o_fifoLevel,
    output logic              o_full,
    output logic [7:0]        o_ovfCnt,
    output logic [7:0]        o_errCnt
`ifdef TOT_WINDOW_EN
    ,
    output logic [7:0]        o_winRejCnt
`endif
);

    // Elaboration-time sanity check of the configuration.
    if (DEPTH < 2 || (1 << ADDR_W) != DEPTH || TOT_MIN > TOT_MAX) begin : g_badCfg
        $error("tot_hit_fifo: DEPTH must be a power of 2 >= 2 with ADDR_W = log2(DEPTH), and TOT_MIN <= TOT_MAX");
    end

    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

    // Saturating statistics counter; a clear wins but keeps a same-edge increment.
    function automatic logic [7:0] satNext(input logic [7:0] cnt,
                                           input logic       inc,
                                           input logic       clr);
        if (clr)
            return {7'd0, inc};
        else if (inc && cnt != 8'hFF)
            return cnt + 8'd1;
        else
            return cnt;
    endfunction

    // Stage-1 register.
    logic              r_stgValid;
    logic [8:0]        r_stgTot;
    logic              r_stgErr;
    logic [5:0]        r_stgEvt;
    logic [5:0]        r_evtId;

    // FIFO storage and bookkeeping.
    logic [15:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_rdPtr;
    logic [ADDR_W:0]   r_level;
    logic [15:0]       r_rdData;

    // Statistics.
    logic [7:0]        r_ovfCnt;
    logic [7:0]        r_errCnt;

    logic              w_rdValid;
    logic              w_full;
    logic              w_pop;
    logic              w_dropErr;
    logic              w_winRej;
    logic              w_keep;
    logic              w_push;
    logic              w_ovfInc;
    logic              w_errInc;
    logic [15:0]       w_stgWord;
    logic [ADDR_W-1:0] w_nextRdPtr;
    logic [ADDR_W:0]   w_levelAfterPop;
    logic              w_bypass;
    logic [15:0]       w_nextHead;

    assign w_rdValid = (r_level != '0);
    assign w_full    = (r_level == LEVEL_FULL);
    assign w_pop     = w_rdValid & o_rd.rdReady;
    assign w_dropErr = i_dropErrors & r_stgErr;

`ifdef TOT_WINDOW_EN
    logic [7:0] r_winRejCnt;

    // Out-of-window words are rejected before they can be counted as overflow.
    assign w_winRej = r_stgValid & ~w_dropErr &
                      ((int'(r_stgTot) < TOT_MIN) | (int'(r_stgTot) > TOT_MAX));
`else
    assign w_winRej = 1'b0;
`endif

    assign w_keep    = r_stgValid & ~w_dropErr & ~w_winRej;
    assign w_push    = w_keep & (~w_full | w_pop);
    assign w_ovfInc  = w_keep & w_full & ~w_pop;
    assign w_errInc  = i_hitValid & i_errorFlag;
    assign w_stgWord = {r_stgErr, r_stgEvt, r_stgTot};

    // Head-of-queue after this edge. When the queue drains to empty on the
    // same edge a word is written, that word becomes the new head directly,
    // which gives the one-cycle write-to-rdValid latency.
    assign w_nextRdPtr     = r_rdPtr + ADDR_W'(w_pop);
    assign w_levelAfterPop = r_level - (ADDR_W+1)'(w_pop);
    assign w_bypass        = w_push & (w_levelAfterPop == '0);
    assign w_nextHead      = w_bypass ? w_stgWord : r_mem[w_nextRdPtr];

    // Capture each hit into the stage register and advance the event ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stgValid <= 1'b0;
            r_stgTot   <= '0;
            r_stgErr   <= 1'b0;
            r_stgEvt   <= '0;
            r_evtId    <= '0;
        end else begin
            r_stgValid <= i_hitValid;
            if (i_hitValid) begin
                r_stgTot <= {i_coarsePhase, i_finePhase};
                r_stgErr <= i_errorFlag;
                r_stgEvt <= r_evtId;
                r_evtId  <= r_evtId + 6'd1;
            end
        end
    end

    // FIFO RAM write; contents need no reset since the level gates them.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wrPtr] <= w_stgWord;
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_level  <= '0;
            r_rdData <= '0;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + ADDR_W'(1);
            r_rdPtr  <= w_nextRdPtr;
            r_level  <= w_levelAfterPop + (ADDR_W+1)'(w_push);
            r_rdData <= w_nextHead;
        end
    end

    // Overflow and error statistics for slow control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovfCnt <= '0;
            r_errCnt <= '0;
        end else begin
            r_ovfCnt <= satNext(r_ovfCnt, w_ovfInc, i_clearStats);
            r_errCnt <= satNext(r_errCnt, w_errInc, i_clearStats);
        end
    end

`ifdef TOT_WINDOW_EN
    // Window reject statistic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_winRejCnt <= '0;
        else
            r_winRejCnt <= satNext(r_winRejCnt, w_winRej, i_clearStats);
    end

    assign o_winRejCnt = r_winRejCnt;
`endif

    assign o_rd.rdValid = w_rdValid;
    assign o_rd.rdData  = r_rdData;
    assign o_fifoLevel  = r_level;
    assign o_full       = w_full;
    assign o_ovfCnt     = r_ovfCnt;
    assign o_errCnt     = r_errCnt;

endmodule

// File: tb/tb_tot_hit_fifo.sv
// Self-checking bench for tot_hit_fifo. A cycle model tracks the stage
// register, expected FIFO contents (scoreboard queue) and statistics.
// Build with +define+TOT_WINDOW_EN to exercise the TOT window filter.
module tb_tot_hit_fifo;

    localparam int DEPTH = 8;
`ifdef TOT_WINDOW_EN
    localparam int TB_MIN = 100;
    localparam int TB_MAX = 400;
`else
    localparam int TB_MIN = 0;
    localparam int TB_MAX = 511;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hitValid;
    logic [2:0] coarsePhase;
    logic [5:0] finePhase;
    logic       errorFlag;
    logic       dropErrors;
    logic       clearStats;
    logic [3:0] fifoLevel;
    logic       full;
    logic [7:0] ovfCnt;
    logic [7:0] errCnt;
`ifdef TOT_WINDOW_EN
    logic [7:0] winRejCnt;
`endif

    tot_hit_fifo_if rdIf ();

    tot_hit_fifo #(
        .DEPTH   (DEPTH),
        .ADDR_W  (3),
        .TOT_MIN (TB_MIN),
        .TOT_MAX (TB_MAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_hitValid    (hitValid),
        .i_coarsePhase (coarsePhase),
        .i_finePhase   (finePhase),
        .i_errorFlag   (errorFlag),
        .i_dropErrors  (dropErrors),
        .i_clearStats  (clearStats),
        .o_rd          (rdIf),
        .o_fifoLevel   (fifoLevel),
        .o_full        (full),
        .o_ovfCnt      (ovfCnt),
        .o_errCnt      (errCnt)
`ifdef TOT_WINDOW_EN
        ,
        .o_winRejCnt   (winRejCnt)
`endif
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // Model state.
    logic [15:0] sbQ [$];
    logic        mStgValid;
    logic [15:0] mStgWord;
    logic [5:0]  mEvt;
    int          mOvf;
    int          mErr;
    int          mWin;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    endtask

    function automatic int bump(input int cnt, input bit inc, input bit clr);
        if (clr)       return inc ? 1 : 0;
        if (inc && cnt < 255) return cnt + 1;
        return cnt;
    endfunction

    // One clock: check the handshake, advance the model, pass the edge,
    // then check occupancy and statistics on the falling edge.
    task automatic tick();
        bit popNow, wasFull, dropE, winRej, keep;
        int tot;
        checkOutput("rdValid", rdIf.rdValid, sbQ.size() != 0);
        popNow  = (sbQ.size() != 0) && rdIf.rdReady;
        if (popNow)
            checkOutput("rdData", rdIf.rdData, sbQ[0]);
        wasFull = (sbQ.size() == DEPTH);
        if (popNow)
            void'(sbQ.pop_front());
        dropE  = mStgValid && dropErrors && mStgWord[15];
        tot    = int'(mStgWord[8:0]);
        winRej = 1'b0;
`ifdef TOT_WINDOW_EN
        winRej = mStgValid && !dropE && (tot < TB_MIN || tot > TB_MAX);
`endif
        keep = mStgValid && !dropE && !winRej;
        if (keep && (!wasFull || popNow))
            sbQ.push_back(mStgWord);
        mOvf = bump(mOvf, keep && wasFull && !popNow, clearStats);
        mErr = bump(mErr, hitValid && errorFlag, clearStats);
        mWin = bump(mWin, winRej, clearStats);
        mStgValid = hitValid;
        if (hitValid) begin
            mStgWord = {errorFlag, mEvt, coarsePhase, finePhase};
            mEvt     = mEvt + 6'd1;
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("fifoLevel", fifoLevel, sbQ.size());
        checkOutput("full", full, sbQ.size() == DEPTH);
        checkOutput("ovfCnt", ovfCnt, mOvf);
        checkOutput("errCnt", errCnt, mErr);
`ifdef TOT_WINDOW_EN
        checkOutput("winRejCnt", winRejCnt, mWin);
`endif
    endtask

    task automatic applyStimulus(input bit hv, input logic [2:0] c, input logic [5:0] f, input bit e);
        hitValid    = hv;
        coarsePhase = c;
        finePhase   = f;
        errorFlag   = e;
        tick();
    endtask

    task automatic modelClear();
        sbQ.delete();
        mStgValid = 1'b0;
        mStgWord  = '0;
        mEvt      = '0;
        mOvf      = 0;
        mErr      = 0;
        mWin      = 0;
    endtask

    task automatic resetDut();
        hitValid   = 1'b0;
        clearStats = 1'b0;
        rst_n      = 1'b0;
        modelClear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drain everything still buffered or staged, with a bounded cycle budget.
    task automatic drain();
        int n = 0;
        rdIf.rdReady = 1'b1;
        while ((sbQ.size() != 0 || mStgValid) && n < DEPTH + 6) begin
            applyStimulus(1'b0, 3'd0, 6'd0, 1'b0);
            n++;
        end
        applyStimulus(1'b0, 3'd0, 6'd0, 1'b0);
        checkOutput("drain_level", fifoLevel, 0);
        checkOutput("drain_rdValid", rdIf.rdValid, 0);
    endtask

    initial begin
        hitValid     = 1'b0;
        coarsePhase  = '0;
        finePhase    = '0;
        errorFlag    = 1'b0;
        dropErrors   = 1'b0;
        clearStats   = 1'b0;
        rdIf.rdReady = 1'b0;
        rst_n        = 1'b0;
        modelClear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_rdValid", rdIf.rdValid, 0);
        checkOutput("reset_level", fifoLevel, 0);
        checkOutput("reset_full", full, 0);
        checkOutput("reset_ovfCnt", ovfCnt, 0);
        checkOutput("reset_errCnt", errCnt, 0);

        $display("[TB] single hit");
        rdIf.rdReady = 1'b1;
        applyStimulus(1'b1, 3'd3, 6'd5, 1'b0);
        checkOutput("single_rdValid_stage", rdIf.rdValid, 0);
        applyStimulus(1'b0, 3'd0, 6'd0, 1'b0);
        checkOutput("single_rdValid", rdIf.rdValid, 1);
        checkOutput("single_rdData", rdIf.rdData, 16'h00C5);
        applyStimulus(1'b0, 3'd0, 6'd0, 1'b0);
        checkOutput("single_level_after_pop", fifoLevel, 0);

        $display("[TB] fill with overflow");
        rdIf.rdReady = 1'b0;
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b1, 3'(2 + (i % 4)), 6'(i * 3), 1'b0);
        applyStimulus(1'b0, 3'd0, 6'd0, 1'b0);
        checkOutput("fill_full", full, 1);
        checkOutput("fill_level", fifoLevel, 8);
        checkOutput("fill_ovfCnt", ovfCnt, 2);
        drain();

        $display("[TB] full with simultaneous push and pop");
        resetDut();
        rdIf.rdReady = 1'b0;
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b1, 3'(2 + (i % 3)), 6'($urandom_range(63)), 1'b0);
        checkOutput("pp_full", full, 1);
        rdIf.rdReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 3'(2 + (i % 3)), 6'($urandom_range(63)), 1'b0);
            checkOutput("pp_level", fifoLevel, 8);
            checkOutput("pp_ovfCnt", ovfCnt, 0);
        end
        drain();

        $display("[TB] error hits dropped");
        resetDut();
        rdIf.rdReady = 1'b0;
        dropErrors   = 1'b1;
        applyStimulus(1'b1, 3'd2, 6'd1, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 3'd3, 6'(10 + i), 1'b1);
        applyStimulus(1'b1, 3'd4, 6'd2, 1'b0);
        applyStimulus(1'b0, 3'd0, 6'd0, 1'b0);
        checkOutput("drop_errCnt", errCnt, 3);
        checkOutput("drop_level", fifoLevel, 2);
        checkOutput("drop_head", rdIf.rdData, {1'b0, 6'd0, 3'd2, 6'd1});
        drain();

        $display("[TB] error hits kept");
        resetDut();
        rdIf.rdReady = 1'b0;
        dropErrors   = 1'b0;
        applyStimulus(1'b1, 3'd2, 6'd1, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 3'd3, 6'(10 + i), 1'b1);
        applyStimulus(1'b1, 3'd4, 6'd2, 1'b0);
        applyStimulus(1'b0, 3'd0, 6'd0, 1'b0);
        checkOutput("keep_errCnt", errCnt, 3);
        checkOutput("keep_level", fifoLevel, 5);
        drain();

        $display("[TB] overflow saturation and clear");
        resetDut();
        rdIf.rdReady = 1'b0;
        for (int i = 0; i < 308; i++)
            applyStimulus(1'b1, 3'($urandom_range(5, 2)), 6'($urandom_range(63)), 1'b0);
        checkOutput("sat_ovfCnt", ovfCnt, 255);
        clearStats = 1'b1;
        applyStimulus(1'b0, 3'd0, 6'd0, 1'b0);
        clearStats = 1'b0;
        checkOutput("clear_ovfCnt", ovfCnt, 1);
        applyStimulus(1'b0, 3'd0, 6'd0, 1'b0);
        checkOutput("hold_ovfCnt", ovfCnt, 1);
        drain();

        $display("[TB] reset mid-operation");
        resetDut();
        rdIf.rdReady = 1'b0;
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 3'd3, 6'(i), i == 2);
        applyStimulus(1'b0, 3'd0, 6'd0, 1'b0);
        checkOutput("pre_reset_level", fifoLevel, 5);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rdValid", rdIf.rdValid, 0);
        checkOutput("async_level", fifoLevel, 0);
        checkOutput("async_errCnt", errCnt, 0);
        checkOutput("async_ovfCnt", ovfCnt, 0);
        modelClear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rdIf.rdReady = 1'b1;
        applyStimulus(1'b1, 3'd5, 6'd9, 1'b0);
        applyStimulus(1'b0, 3'd0, 6'd0, 1'b0);
        checkOutput("post_reset_evt0", rdIf.rdData, {1'b0, 6'd0, 3'd5, 6'd9});
        drain();

`ifdef TOT_WINDOW_EN
        $display("[TB] TOT window");
        resetDut();
        rdIf.rdReady = 1'b0;
        applyStimulus(1'b1, 3'd0, 6'd50, 1'b0);
        applyStimulus(1'b1, 3'd3, 6'd8, 1'b0);
        applyStimulus(1'b1, 3'd7, 6'd2, 1'b0);
        applyStimulus(1'b0, 3'd0, 6'd0, 1'b0);
        checkOutput("win_level", fifoLevel, 1);
        checkOutput("win_rejCnt", winRejCnt, 2);
        checkOutput("win_ovfCnt", ovfCnt, 0);
        drain();
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
